// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 command transmitter.
// It runs the request-to-send handshake:
//   1. hold PS2_CLK low,
//   2. drive the start bit,
//   3. shift out data[7:0] LSB-first, then odd parity and stop on device clock falling edges,
//   4. sample the device ACK.
// Both pads are driven only as open-drain pull-downs through the *_oe outputs.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 10000,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
  localparam logic [INH_W-1:0] INH_ONE  = INH_W'(1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1);

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    RTS,
    SHIFT,
    ACK,
    WAIT_REL
  } state_t;

  state_t           state_reg, state_next;
  logic [9:0]       shreg_reg, shreg_next;      // {stop, parity, data[7:0]}
  logic [3:0]       bit_cnt_reg, bit_cnt_next;
  logic [INH_W-1:0] inh_cnt_reg, inh_cnt_next;
  logic [TMO_W-1:0] tmo_cnt_reg, tmo_cnt_next;
  logic             clk_oe_reg, clk_oe_next;
  logic             data_oe_reg, data_oe_next;
  logic             busy_reg, busy_next;
  logic             done_reg, done_next;
  logic             err_reg, err_next;
  logic             clk_prev_reg;

  // Pad synchronizers: index 0 = PS2_CLK, index 1 = PS2_DATA.
  logic [1:0] pad_raw;
  logic [1:0] pad_sync;
  assign pad_raw = {ps2_data_in, ps2_clk_in};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_sync
      logic meta_reg;
      logic sync_reg;
      // Two-flop synchronizer; resets to the idle-high bus level so no false edge follows reset.
      always_ff @(posedge clk) begin
        if (rst) begin
          meta_reg <= 1'b1;
          sync_reg <= 1'b1;
        end else begin
          meta_reg <= pad_raw[gi];
          sync_reg <= meta_reg;
        end
      end
      assign pad_sync[gi] = sync_reg;
    end
  endgenerate

  logic clk_sync;
  logic data_sync;
  logic clk_fe;
  logic accept;
  logic tmo_hit;

  assign clk_sync  = pad_sync[0];
  assign data_sync = pad_sync[1];
  assign clk_fe    = clk_prev_reg & ~clk_sync;
  assign tx_ready  = (state_reg == IDLE) && !rst;
  assign accept    = tx_valid && tx_ready;
  assign tmo_hit   = (tmo_cnt_reg == TMO_LAST);

  // Previous synced clock level, used for falling-edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_prev_reg <= 1'b1;
    end else begin
      clk_prev_reg <= clk_sync;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      shreg_reg   <= '0;
      bit_cnt_reg <= '0;
      inh_cnt_reg <= '0;
      tmo_cnt_reg <= '0;
      clk_oe_reg  <= 1'b0;
      data_oe_reg <= 1'b0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      err_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      shreg_reg   <= shreg_next;
      bit_cnt_reg <= bit_cnt_next;
      inh_cnt_reg <= inh_cnt_next;
      tmo_cnt_reg <= tmo_cnt_next;
      clk_oe_reg  <= clk_oe_next;
      data_oe_reg <= data_oe_next;
      busy_reg    <= busy_next;
      done_reg    <= done_next;
      err_reg     <= err_next;
    end
  end

  // Next-state logic. Outputs are computed for the next cycle, so every output is registered.
  always_comb begin
    state_next   = state_reg;
    shreg_next   = shreg_reg;
    bit_cnt_next = bit_cnt_reg;
    inh_cnt_next = inh_cnt_reg;
    tmo_cnt_next = tmo_cnt_reg;
    clk_oe_next  = 1'b0;
    data_oe_next = data_oe_reg;
    done_next    = 1'b0;
    err_next     = 1'b0;

    case (state_reg)
      IDLE: begin
        data_oe_next = 1'b0;
        if (accept) begin
          shreg_next   = {1'b1, ~^tx_data, tx_data};
          inh_cnt_next = '0;
          clk_oe_next  = 1'b1;
          state_next   = INHIBIT;
        end
      end

      INHIBIT: begin
        data_oe_next = 1'b0;
        if (inh_cnt_reg == INH_LAST) begin
          // Hand over from clock inhibit to start bit on the same edge.
          data_oe_next = 1'b1;
          tmo_cnt_next = '0;
          bit_cnt_next = '0;
          state_next   = RTS;
        end else begin
          clk_oe_next  = 1'b1;
          inh_cnt_next = inh_cnt_reg + INH_ONE;
        end
      end

      RTS: begin
        data_oe_next = 1'b1;
        tmo_cnt_next = tmo_cnt_reg + TMO_ONE;
        state_next   = SHIFT;
        if (tmo_hit) begin
          data_oe_next = 1'b0;
          err_next     = 1'b1;
          state_next   = IDLE;
        end
      end

      SHIFT: begin
        tmo_cnt_next = tmo_cnt_reg + TMO_ONE;
        if (tmo_hit) begin
          data_oe_next = 1'b0;
          err_next     = 1'b1;
          state_next   = IDLE;
        end else if (clk_fe) begin
          data_oe_next = ~shreg_reg[bit_cnt_reg];
          bit_cnt_next = bit_cnt_reg + 4'd1;
          if (bit_cnt_reg == 4'd9) begin
            state_next = ACK;
          end
        end
      end

      ACK: begin
        data_oe_next = 1'b0;
        tmo_cnt_next = tmo_cnt_reg + TMO_ONE;
        // The ACK edge takes priority over a timeout on the same cycle.
        if (clk_fe) begin
          done_next  = ~data_sync;
          err_next   = data_sync;
          state_next = WAIT_REL;
        end else if (tmo_hit) begin
          err_next   = 1'b1;
          state_next = IDLE;
        end
      end

      WAIT_REL: begin
        data_oe_next = 1'b0;
        if (clk_sync && data_sync) begin
          state_next = IDLE;
        end
      end

      default: begin
        data_oe_next = 1'b0;
        state_next   = IDLE;
      end
    endcase

    busy_next = (state_next != IDLE);
  end

  assign ps2_clk_oe  = clk_oe_reg;
  assign ps2_data_oe = data_oe_reg;
  assign busy        = busy_reg;
  assign done        = done_reg;
  assign err         = err_reg;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: drives ps2_host_tx against a simple PS/2 device model on a wired-AND bus.
// Frames come from a fixed table and from random bytes; expectations come from the
// protocol rules: LSB-first data, odd parity, stop high, and ACK low meaning done.
module tb_ps2_host_tx;

  localparam int INH  = 20;
  localparam int TMO  = 600;
  localparam int HALF = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       dev_clk = 1'b1;
  logic       dev_data = 1'b1;
  logic       tx_ready;
  logic       ps2_clk_in;
  logic       ps2_data_in;
  logic       ps2_clk_oe;
  logic       ps2_data_oe;
  logic       busy;
  logic       done;
  logic       err;

  // Open-drain bus: either side can pull a line low.
  assign ps2_clk_in  = dev_clk & ~ps2_clk_oe;
  assign ps2_data_in = dev_data & ~ps2_data_oe;

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk        (clk),
    .rst        (rst),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .ps2_clk_in (ps2_clk_in),
    .ps2_data_in(ps2_data_in),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int both_cnt = 0;

  // Pulse counters, sampled away from the active edge.
  always @(negedge clk) begin
    if (done) done_cnt++;
    if (err) err_cnt++;
    if (done && err) both_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Wait for tx_ready, present one byte, and measure the clock-inhibit phase.
  // Returns on the first sample taken in RTS.
  task automatic start_tx(input logic [7:0] d, input string tag);
    int   n;
    logic overlap;
    n = 0;
    while (!tx_ready && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check({tag, " ready_before_send"}, 32'(tx_ready), 32'd1);
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    check({tag, " accept_clk_oe"}, 32'(ps2_clk_oe), 32'd1);
    check({tag, " accept_busy"}, 32'(busy), 32'd1);
    n = 0;
    overlap = 1'b0;
    while (ps2_clk_oe && n < INH + 50) begin
      if (ps2_data_oe) overlap = 1'b1;
      n++;
      @(negedge clk);
    end
    check({tag, " inhibit_len"}, 32'(n), 32'(INH));
    check({tag, " inhibit_overlap"}, 32'(overlap), 32'd0);
    check({tag, " rts_data_oe"}, 32'(ps2_data_oe), 32'd1);
  endtask

  // Device clock generator. It samples the line on each rising edge after falls 1..10
  // and pulls data low before fall 11 when ack is set. It pokes tx_valid on fall poke_edge.
  task automatic dev_clock(input int n_edges, input logic ack, input int poke_edge,
                           output logic [9:0] bits);
    bits = '0;
    repeat (6) @(negedge clk);
    for (int e = 1; e <= n_edges; e++) begin
      if (e == 11) dev_data = ~ack;
      repeat (2) @(negedge clk);
      dev_clk = 1'b0;
      if (e == poke_edge) begin
        tx_data  = 8'hAA;
        tx_valid = 1'b1;
      end
      repeat (HALF) @(negedge clk);
      tx_valid = 1'b0;
      if (e <= 10) bits[e-1] = ps2_data_in;
      dev_clk = 1'b1;
      repeat (HALF) @(negedge clk);
    end
    dev_data = 1'b1;
  endtask

  // Run one frame end to end and compare it with the expected line bits and result pulse.
  task automatic run_frame(input logic [7:0] d, input logic ack, input logic exp_parity,
                           input logic exp_done, input logic exp_err, input int poke,
                           input string tag);
    logic [9:0] bits;
    int d0, e0, n;
    d0 = done_cnt;
    e0 = err_cnt;
    start_tx(d, tag);
    dev_clock(11, ack, poke, bits);
    n = 0;
    while (!tx_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({tag, " ready_after_frame"}, 32'(tx_ready), 32'd1);
    check({tag, " busy_after_frame"}, 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    check({tag, " data_bits"}, 32'(bits[7:0]), 32'(d));
    check({tag, " parity_bit"}, 32'(bits[8]), 32'(exp_parity));
    check({tag, " stop_bit"}, 32'(bits[9]), 32'd1);
    check({tag, " done_pulses"}, 32'(done_cnt - d0), 32'(exp_done));
    check({tag, " err_pulses"}, 32'(err_cnt - e0), 32'(exp_err));
    check({tag, " oe_released"}, {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       ack;
    logic       exp_parity;
    logic       exp_done;
    logic       exp_err;
    string      tag;
  } vec_t;

  vec_t vecs[5];

  initial begin
    logic [9:0] bits;
    logic [7:0] d;
    logic       a;
    int         k, d0, e0;

    vecs[0] = '{8'hED, 1'b1, 1'b1, 1'b1, 1'b0, "ed_ack"};
    vecs[1] = '{8'h00, 1'b1, 1'b1, 1'b1, 1'b0, "par_00"};
    vecs[2] = '{8'hFF, 1'b1, 1'b1, 1'b1, 1'b0, "par_ff"};
    vecs[3] = '{8'h01, 1'b1, 1'b0, 1'b1, 1'b0, "par_01"};
    vecs[4] = '{8'hF4, 1'b0, 1'b0, 1'b0, 1'b1, "f4_noack"};

    // Reset state.
    repeat (3) @(negedge clk);
    check("reset clk_oe", 32'(ps2_clk_oe), 32'd0);
    check("reset data_oe", 32'(ps2_data_oe), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done_err", {30'd0, done, err}, 32'd0);
    check("reset tx_ready", 32'(tx_ready), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post_reset tx_ready", 32'(tx_ready), 32'd1);

    // Table-driven frames.
    for (int i = 0; i < 5; i++) begin
      run_frame(vecs[i].data, vecs[i].ack, vecs[i].exp_parity, vecs[i].exp_done,
                vecs[i].exp_err, 0, vecs[i].tag);
      $display("[TB] frame %s data=0x%02h ack=%0d", vecs[i].tag, vecs[i].data, vecs[i].ack);
    end

    // Random frames against the protocol-level model.
    for (int r = 0; r < 6; r++) begin
      d = 8'($urandom_range(0, 255));
      a = 1'($urandom_range(0, 1));
      run_frame(d, a, ($countones(d) % 2) == 0, a, ~a, 0, $sformatf("rand%0d", r));
      $display("[TB] frame rand%0d data=0x%02h ack=%0d", r, d, a);
    end

    // Timeout: the device never clocks after RTS.
    start_tx(8'h3C, "timeout");
    k = 0;
    while (!err && k < TMO + 100) begin
      @(negedge clk);
      k++;
    end
    check("timeout cycles", 32'(k), 32'(TMO));
    check("timeout data_oe", 32'(ps2_data_oe), 32'd0);
    check("timeout clk_oe", 32'(ps2_clk_oe), 32'd0);
    @(negedge clk);
    check("timeout tx_ready", 32'(tx_ready), 32'd1);
    $display("[TB] frame timeout data=0x3c cycles=%0d", k);

    // Reset mid-frame after fall 5. Data bit 4 of 0x4A is 0, so data_oe is high.
    d0 = done_cnt;
    e0 = err_cnt;
    start_tx(8'h4A, "midrst");
    dev_clock(5, 1'b1, 0, bits);
    check("midrst bits", 32'(bits[4:0]), 32'h0A);
    check("midrst pre data_oe", 32'(ps2_data_oe), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("midrst oe", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
    check("midrst busy", 32'(busy), 32'd0);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("midrst no_pulse", 32'((done_cnt - d0) + (err_cnt - e0)), 32'd0);
    $display("[TB] frame midrst data=0x4a aborted");
    run_frame(8'hFF, 1'b1, 1'b1, 1'b1, 1'b0, 0, "after_rst");
    $display("[TB] frame after_rst data=0xff ack=1");

    // Request while busy: 0xAA poked during the shift of 0xED must be dropped.
    run_frame(8'hED, 1'b1, 1'b1, 1'b1, 1'b0, 3, "busy_req");
    repeat (INH + 10) @(negedge clk);
    check("busy_req not_queued", 32'(busy), 32'd0);
    $display("[TB] frame busy_req data=0xed ack=1 poke=0xaa");

    check("done_err_overlap", 32'(both_cnt), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
